pc_unit_v2: RTL and testbench

Parametrised program-counter unit for the fetch stage of the RISC-V core. It holds the architectural fetch PC and presents it to instruction memory through a valid/ready handshake. It applies redirects from execute (branch, JAL, JALR) and from the trap logic (trap entry, MRET), and detects misaligned control-flow targets. It also supports stall, and halt/resume for debug, through a three-state controller.

---
 rtl/pc_unit_v2.sv | 142 ++++++++++++++
 tb/tb_pc_unit_v2.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_v2.sv
// pc_unit_v2 -- fetch-stage program counter.
//
// Holds the architectural fetch PC and offers it to instruction memory with a
// valid/ready handshake. It applies execute redirects (branch, JAL, JALR) and
// trap-logic redirects (trap entry, MRET), and refuses misaligned execute
// targets. A BOOT/RUN/HALTED controller handles debug halt and resume.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   pc_valid/pc_ready   fetch request handshake (pc_valid only in RUN)
//   stall               blocks only the sequential advance
//   taken_br, is_jal, br_tgt_pc     branch / JAL redirect
//   is_jalr, jalr_tgt_pc            JALR redirect (bit 0 cleared here)
//   trap_req, trap_vec              trap entry redirect
//   mret, mepc                      trap return redirect
//   halt_req, resume                debug halt control
//   pc                  registered fetch PC
//   redirect_flush      combinational, a redirect is taken at the next edge
//   misalign_exc        registered one-cycle pulse on a rejected target
//   misalign_addr       last rejected target
//   halted              controller is in HALTED
module pc_unit_v2 #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     IALIGN       = 32,
    parameter int unsigned     INSN_BYTES   = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic            stall,
    input  logic            taken_br,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] br_tgt_pc,
    input  logic [XLEN-1:0] jalr_tgt_pc,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic            redirect_flush,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // Low target bits that must be zero: [0] for 16-bit alignment, [1:0] otherwise.
    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(INSN_BYTES);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_misalign_exc;
    logic [XLEN-1:0] r_misalign_addr;

    logic            w_run;
    logic            w_exe_redirect;
    logic [XLEN-1:0] w_exe_tgt;
    logic            w_exe_bad;
    logic            w_seq_adv;
    logic            w_flush;
    logic            w_misalign;

    assign w_run          = (r_state == S_RUN);
    assign w_exe_redirect = taken_br | is_jal | is_jalr;
    // Branch/JAL outrank JALR when execute raises both.
    assign w_exe_tgt      = (taken_br | is_jal) ? br_tgt_pc
                                                : {jalr_tgt_pc[XLEN-1:1], 1'b0};
    assign w_exe_bad      = |(w_exe_tgt & ALIGN_MASK);
    assign w_seq_adv      = w_run & pc_ready & ~stall;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush     = 1'b0;
        w_misalign  = 1'b0;
        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN: begin
                // A redirect in the halting cycle still lands; pc shows it while halted.
                if (halt_req)
                    w_state_nxt = S_HALTED;
                if (trap_req) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = trap_vec;
                end else if (mret) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = mepc;
                end else if (w_exe_redirect) begin
                    // A misaligned target still flushes, but the PC holds.
                    w_flush = 1'b1;
                    if (w_exe_bad)
                        w_misalign = 1'b1;
                    else
                        w_pc_nxt = w_exe_tgt;
                end else if (w_seq_adv) begin
                    w_pc_nxt = r_pc + PC_INC;
                end
            end
            S_HALTED: begin
                if (resume)
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_BOOT;
            r_pc            <= RESET_VECTOR;
            r_misalign_exc  <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_misalign_exc <= w_misalign;
            if (w_misalign)
                r_misalign_addr <= w_exe_tgt;
        end
    end

    assign pc             = r_pc;
    assign pc_valid       = w_run;
    assign redirect_flush = w_flush;
    assign misalign_exc   = r_misalign_exc;
    assign misalign_addr  = r_misalign_addr;
    assign halted         = (r_state == S_HALTED);

endmodule

// File: tb/tb_pc_unit_v2.sv
// Bench for pc_unit_v2: two instances share stimulus, one with 32-bit and one
// with 16-bit instruction alignment. A directed table, short hand-written
// reset sequences and a random run against a behavioural model.
module tb_pc_unit_v2;

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam int ST_BOOT = 0, ST_RUN = 1, ST_HALT = 2;

    typedef struct {
        bit trap, mret, br, jal, jalr, stall, ready, halt, resume;
        logic [31:0] tvec, mepc, btgt, jtgt;
    } in_t;

    typedef struct {
        in_t         in;
        bit          flush;
        logic [31:0] pc, pc16;
        bit          exc, halted;
        logic [31:0] addr;
    } vec_t;

    typedef struct {
        int          st;
        logic [31:0] pc, addr;
        bit          exc;
    } mstate_t;

    logic        clk, rst;
    logic        pc_ready, stall, taken_br, is_jal, is_jalr, trap_req, mret, halt_req, resume;
    logic [31:0] br_tgt_pc, jalr_tgt_pc, trap_vec, mepc;
    logic        pc_valid, redirect_flush, misalign_exc, halted;
    logic [31:0] pc, misalign_addr;
    logic        pc_valid16, redirect_flush16, misalign_exc16, halted16;
    logic [31:0] pc16, misalign_addr16;

    int n_tests = 0;
    int n_fail  = 0;

    pc_unit_v2 #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(32), .INSN_BYTES(4)) dut (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_ready(pc_ready), .stall(stall),
        .taken_br(taken_br), .is_jal(is_jal), .is_jalr(is_jalr), .br_tgt_pc(br_tgt_pc),
        .jalr_tgt_pc(jalr_tgt_pc), .trap_req(trap_req), .trap_vec(trap_vec), .mret(mret),
        .mepc(mepc), .halt_req(halt_req), .resume(resume), .pc(pc),
        .redirect_flush(redirect_flush), .misalign_exc(misalign_exc),
        .misalign_addr(misalign_addr), .halted(halted)
    );

    pc_unit_v2 #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(16), .INSN_BYTES(4)) dut16 (
        .clk(clk), .rst(rst), .pc_valid(pc_valid16), .pc_ready(pc_ready), .stall(stall),
        .taken_br(taken_br), .is_jal(is_jal), .is_jalr(is_jalr), .br_tgt_pc(br_tgt_pc),
        .jalr_tgt_pc(jalr_tgt_pc), .trap_req(trap_req), .trap_vec(trap_vec), .mret(mret),
        .mepc(mepc), .halt_req(halt_req), .resume(resume), .pc(pc16),
        .redirect_flush(redirect_flush16), .misalign_exc(misalign_exc16),
        .misalign_addr(misalign_addr16), .halted(halted16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mki(bit trap, bit mr, bit br, bit jal, bit jalr, bit st, bit rdy,
                                bit hlt, bit res, logic [31:0] a, logic [31:0] b, logic [31:0] c);
        in_t x;
        x.trap = trap; x.mret = mr; x.br = br; x.jal = jal; x.jalr = jalr;
        x.stall = st; x.ready = rdy; x.halt = hlt; x.resume = res;
        x.tvec = a; x.mepc = a; x.btgt = b; x.jtgt = c;
        return x;
    endfunction

    function automatic vec_t mkv(in_t x, bit fl, logic [31:0] p, logic [31:0] p16,
                                 bit exc, bit hl, logic [31:0] addr);
        vec_t v;
        v.in = x; v.flush = fl; v.pc = p; v.pc16 = p16; v.exc = exc; v.halted = hl; v.addr = addr;
        return v;
    endfunction

    task automatic drive(input in_t x);
        trap_req = x.trap; trap_vec = x.tvec; mret = x.mret; mepc = x.mepc;
        taken_br = x.br; is_jal = x.jal; is_jalr = x.jalr;
        br_tgt_pc = x.btgt; jalr_tgt_pc = x.jtgt;
        stall = x.stall; pc_ready = x.ready; halt_req = x.halt; resume = x.resume;
    endtask

    // Reference model: next state straight from the architectural rules.
    function automatic bit m_flush(mstate_t s, in_t x);
        return (s.st == ST_RUN) && (x.trap || x.mret || x.br || x.jal || x.jalr);
    endfunction

    function automatic mstate_t m_step(mstate_t s, in_t x, int ialign);
        mstate_t     n;
        logic [31:0] tgt;
        n = s;
        n.exc = 0;
        if (s.st == ST_BOOT) begin
            n.st = ST_RUN;
        end else if (s.st == ST_HALT) begin
            if (x.resume) n.st = ST_RUN;
        end else begin
            if (x.halt) n.st = ST_HALT;
            if (x.trap) n.pc = x.tvec;
            else if (x.mret) n.pc = x.mepc;
            else if (x.br || x.jal || x.jalr) begin
                tgt = (x.br || x.jal) ? x.btgt : (x.jtgt & ~32'd1);
                if (tgt % (ialign / 8) != 0) begin
                    n.exc  = 1;
                    n.addr = tgt;
                end else begin
                    n.pc = tgt;
                end
            end else if (x.ready && !x.stall) begin
                n.pc = s.pc + 32'd4;
            end
        end
        return n;
    endfunction

    vec_t    tv[18];
    in_t     idle, x;
    mstate_t m32, m16;
    logic [31:0] rb, rc;

    initial begin
        idle = mki(0,0,0,0,0, 0,1,0,0, 0,0,0);
        //             trap mret br jal jalr stall rdy halt res  tvec/mepc       btgt    jtgt
        tv[0]  = mkv(mki(1,0,0,0,0, 0,1,0,0, 32'h100,      0,      0), 1, 32'h100, 32'h100, 0,0,0);
        tv[1]  = mkv(mki(0,0,0,0,0, 0,0,0,0, 0,            0,      0), 0, 32'h100, 32'h100, 0,0,0);
        tv[2]  = mkv(mki(0,0,0,0,0, 1,1,0,0, 0,            0,      0), 0, 32'h100, 32'h100, 0,0,0);
        tv[3]  = mkv(mki(0,0,0,0,0, 1,0,0,0, 0,            0,      0), 0, 32'h100, 32'h100, 0,0,0);
        tv[4]  = mkv(mki(0,0,0,0,0, 0,1,0,0, 0,            0,      0), 0, 32'h104, 32'h104, 0,0,0);
        tv[5]  = mkv(mki(0,0,1,0,1, 0,1,0,0, 0,      32'h200, 32'h301), 1, 32'h200, 32'h200, 0,0,0);
        tv[6]  = mkv(mki(0,0,0,0,1, 0,1,0,0, 0,            0, 32'h301), 1, 32'h300, 32'h300, 0,0,0);
        tv[7]  = mkv(mki(1,0,1,0,0, 0,1,0,0, 32'h1000, 32'h500,     0), 1, 32'h1000, 32'h1000, 0,0,0);
        tv[8]  = mkv(mki(0,1,0,0,0, 0,1,0,0, 32'h204,      0,      0), 1, 32'h204, 32'h204, 0,0,0);
        tv[9]  = mkv(mki(1,0,0,0,0, 0,0,0,0, 32'h40,       0,      0), 1, 32'h40,  32'h40,  0,0,0);
        tv[10] = mkv(mki(0,0,0,1,0, 0,1,0,0, 0,      32'h102,      0), 1, 32'h40,  32'h102, 1,0,32'h102);
        tv[11] = mkv(mki(0,0,0,0,0, 0,0,0,0, 0,            0,      0), 0, 32'h40,  32'h102, 0,0,32'h102);
        tv[12] = mkv(mki(1,0,0,0,0, 0,1,0,0, 32'hFFFF_FFFC, 0,     0), 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0,0,32'h102);
        tv[13] = mkv(mki(0,0,0,0,0, 0,1,0,0, 0,            0,      0), 0, 32'h0,   32'h0,   0,0,32'h102);
        tv[14] = mkv(mki(0,0,1,0,0, 0,1,1,0, 0,       32'h80,      0), 1, 32'h80,  32'h80,  0,1,32'h102);
        tv[15] = mkv(mki(1,0,1,0,0, 0,1,0,0, 32'h999, 32'h700,     0), 0, 32'h80,  32'h80,  0,1,32'h102);
        tv[16] = mkv(mki(0,0,0,0,0, 0,1,1,1, 0,            0,      0), 0, 32'h80,  32'h80,  0,0,32'h102);
        tv[17] = mkv(mki(0,0,0,0,0, 0,1,0,0, 0,            0,      0), 0, 32'h84,  32'h84,  0,0,32'h102);

        // Reset values, then boot with RESET_VECTOR = 8000_0000.
        rst = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk ("rst_pc", pc, RV);
        chkb("rst_valid", pc_valid, 1'b0);
        chkb("rst_flush", redirect_flush, 1'b0);
        chkb("rst_exc", misalign_exc, 1'b0);
        chk ("rst_addr", misalign_addr, 32'h0);
        chkb("rst_halted", halted, 1'b0);
        rst = 1'b0;
        drive(mki(1,0,1,0,0, 0,1,0,0, 32'h55, 32'h66, 0));
        #1;
        chkb("boot_valid", pc_valid, 1'b0);
        chkb("boot_flush", redirect_flush, 1'b0);
        @(posedge clk); #1;
        drive(idle);
        chk ("boot_pc0", pc, RV);
        chkb("boot_valid1", pc_valid, 1'b1);
        @(posedge clk); #1;
        chk ("boot_pc1", pc, RV + 32'd4);
        @(posedge clk); #1;
        chk ("boot_pc2", pc, RV + 32'd8);

        // Directed table.
        for (int i = 0; i < 18; i++) begin
            drive(tv[i].in);
            #1;
            chkb($sformatf("tv%0d_flush", i), redirect_flush, tv[i].flush);
            @(posedge clk); #1;
            chk ($sformatf("tv%0d_pc", i), pc, tv[i].pc);
            chk ($sformatf("tv%0d_pc16", i), pc16, tv[i].pc16);
            chkb($sformatf("tv%0d_exc", i), misalign_exc, tv[i].exc);
            chk ($sformatf("tv%0d_addr", i), misalign_addr, tv[i].addr);
            chkb($sformatf("tv%0d_halted", i), halted, tv[i].halted);
            chkb($sformatf("tv%0d_valid", i), pc_valid, !tv[i].halted);
        end

        // Reset while halted takes effect without a clock edge.
        drive(mki(0,0,0,0,0, 0,1,1,0, 0,0,0));
        @(posedge clk); #1;
        chkb("hr_halted", halted, 1'b1);
        chk ("hr_pc", pc, 32'h88);
        rst = 1'b1;
        #1;
        chk ("hr_rst_pc", pc, RV);
        chk ("hr_rst_pc16", pc16, 32'h0);
        chkb("hr_rst_halted", halted, 1'b0);
        chkb("hr_rst_valid", pc_valid, 1'b0);
        drive(idle);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Misalign pulse cleared by reset.
        drive(mki(0,0,0,1,0, 0,1,0,0, 0, 32'h102, 0));
        @(posedge clk); #1;
        chkb("mr_exc", misalign_exc, 1'b1);
        chk ("mr_addr", misalign_addr, 32'h102);
        chk ("mr_pc", pc, RV);
        rst = 1'b1;
        #1;
        chkb("mr_rst_exc", misalign_exc, 1'b0);
        chk ("mr_rst_addr", misalign_addr, 32'h0);
        drive(idle);
        #2 rst = 1'b0;

        // Random run against the model.
        m32 = '{st: ST_BOOT, pc: RV,    addr: 32'h0, exc: 1'b0};
        m16 = '{st: ST_BOOT, pc: 32'h0, addr: 32'h0, exc: 1'b0};
        for (int c = 0; c < 300; c++) begin
            rb = $urandom;
            rc = $urandom;
            if ($urandom % 2 == 0) rb[1:0] = 2'b00;
            if ($urandom % 2 == 0) rc[1:0] = 2'b00;
            x = mki($urandom % 16 == 0, $urandom % 16 == 0, $urandom % 4 == 0,
                    $urandom % 8 == 0, $urandom % 8 == 0, $urandom % 4 == 0,
                    $urandom % 4 != 0, $urandom % 20 == 0, $urandom % 3 == 0,
                    ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & ~32'd3), rb, rc);
            drive(x);
            #1;
            chk ("rnd_pc", pc, m32.pc);
            chkb("rnd_valid", pc_valid, m32.st == ST_RUN);
            chkb("rnd_halted", halted, m32.st == ST_HALT);
            chkb("rnd_flush", redirect_flush, m_flush(m32, x));
            chkb("rnd_exc", misalign_exc, m32.exc);
            chk ("rnd_addr", misalign_addr, m32.addr);
            chk ("rnd_pc16", pc16, m16.pc);
            chkb("rnd_exc16", misalign_exc16, m16.exc);
            chk ("rnd_addr16", misalign_addr16, m16.addr);
            @(posedge clk); #1;
            m32 = m_step(m32, x, 32);
            m16 = m_step(m16, x, 16);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
